tpm_spi_ctrl: RTL and testbench
===============================

Name: tpm_spi_ctrl

Overview:
- Single-byte TPM-over-SPI transaction initiator: the host-side counterpart of our SPI TPM peripheral.
- On a start strobe it drives CS#, SCLK and MOSI through a 4-byte TPM header, handles TPM wait-state polling, then writes or reads one data byte.
- Serves as the bench driver for the peripheral and as the host engine in loopback/integration builds.
- SPI mode 0: SCLK idles low, MOSI changes while SCLK is low, MISO is sampled on SCLK rising.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk_i cycles (>=1).
- ADDR_HI, 8'hD4: header byte 1, the TPM locality/address high byte.
- MAX_WAIT, 16: maximum wait-state bytes before abort (>=1).

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  transaction request, sampled when busy_o=0.
- wr_i  input  1  1=TPM write, 0=TPM read; latched on start.
- addr_i  input  16  TPM register address; latched on start.
- data_i  input  8  write data; latched on start.
- data_o  output  8  read data; valid from the done_o cycle onward.
- busy_o  output  1  transaction in progress (start ignored).
- done_o  output  1  one-cycle completion pulse.
- timeout_o  output  1  one-cycle pulse, coincident with done_o, on wait abort.
- cs_n_o  output  1  SPI chip select, active low.
- sclk_o  output  1  SPI clock.
- mosi_o  output  1  controller out, MSB first.
- miso_i  input  1  peripheral out.

Behaviour:
- Reset (async): cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, timeout_o=0, data_o=8'h00, FSM=IDLE. Reset mid-transaction aborts immediately; no done_o is produced.
- All outputs are registered. Header = {wr_i?8'h00:8'h80, ADDR_HI, addr_i[15:8], addr_i[7:0]}; the size field is 0 (one byte).
- FSM states and transitions:
  - IDLE: on start_i=1, latch inputs, busy_o=1, cs_n_o=0 next cycle, go to SETUP.
  - SETUP: CLK_DIV cycles with SCLK low and MOSI = header bit 31, then go to HDR.
  - HDR: 32 bits. Each bit is CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high. MOSI updates on the clk_i edge where SCLK falls. MISO is sampled on the edge where SCLK rises.
    - Sample at bit 0 of the header = 1: go to DATA.
    - Sample = 0: go to WAIT with wait count = 0.
  - WAIT: 8 bits per wait byte, MOSI=0. At the byte's last rising edge:
    - MISO=1: go to DATA.
    - Otherwise increment the count; if count==MAX_WAIT, go to HOLD with abort flag set.
  - DATA: 8 bits.
    - Write: MOSI = data byte MSB first; MISO is ignored.
    - Read: MOSI=0; MISO is shifted in MSB first.
  - HOLD: SCLK low for CLK_DIV cycles, then cs_n_o=1 and done_o=1 for one cycle.
    - Read without abort: data_o updates in the same cycle.
    - Abort: timeout_o=1 and data_o unchanged.
  - GUARD: CS# high for CLK_DIV cycles, then busy_o=0 and back to IDLE.
- SCLK never toggles while cs_n_o=1. There is exactly one SCLK rising edge per bit.
- start_i while busy_o=1, including the done_o cycle, is ignored and not queued.
- Latency with CLK_DIV=D and W wait bytes:
  - start accepted at cycle 0; cs_n_o low at cycle 1;
  - done_o at cycle 1 + D + (40 + 8W)·2D + D;
  - busy_o low D cycles later.
- For D=2, W=0: done_o at cycle 165, busy_o falls at cycle 167.
- Simultaneous start_i and async reset: reset wins.

Test Plan:
- Write, no wait: wr=1, addr=16'h0018, data=8'h5A, peripheral model drives 1 at header bit 0 -> MOSI bytes 00 D4 00 18 5A; 40 SCLK rising edges within one CS# low; done_o at cycle 165 (D=2); timeout_o=0.
- Read, two wait states: wr=0, addr=16'h0F00; model returns 0 at header end, 00 then 01 as wait bytes, then 8'hA7 -> MOSI 80 D4 0F 00 then 00×3; 56 SCLK edges; data_o=8'hA7 at done_o.
- Timeout: MAX_WAIT=4, MISO stuck 0 -> exactly 4 wait bytes (64 edges total), cs_n_o rises, done_o and timeout_o pulse together, data_o keeps its previous value.
- Start while busy: pulse start_i mid-HDR and on the done_o cycle -> no effect, MOSI stream unchanged; a start after busy_o falls begins a fresh transaction.
- Reset mid-header: assert rst_n_i=0 during byte 2 -> cs_n_o=1, sclk_o=0, busy_o=0 immediately, no done_o; the next transaction completes normally.
- CLK_DIV=1 and CLK_DIV=5 sweeps of the write case -> SCLK half-period equals CLK_DIV cycles and byte streams are identical.

Source files
------------

// File: rtl/tpm_spi_ctrl.sv
// tpm_spi_ctrl
// Host-side initiator for single-byte TPM-over-SPI transactions (SPI mode 0).
// On a start strobe it sends the 4-byte TPM header, polls TPM wait states,
// then writes or reads one data byte. The transaction ends with a done pulse.
//
// Parameters:
//   CLK_DIV  - SCLK half-period in clk_i cycles (>= 1)
//   ADDR_HI  - header byte 1 (locality / address high byte)
//   MAX_WAIT - wait-state bytes tolerated before the transfer is aborted (>= 1)
//
// Ports:
//   clk_i, rst_n_i    - system clock, asynchronous active-low reset
//   start_i           - transaction request, sampled while busy_o is low
//   wr_i              - 1 = TPM write, 0 = TPM read (latched on start)
//   addr_i            - 16-bit TPM register address (latched on start)
//   data_i            - write data (latched on start)
//   data_o            - read data, valid from the done_o cycle onward
//   busy_o            - transaction in progress
//   done_o            - one-cycle completion pulse
//   timeout_o         - one-cycle pulse with done_o when wait polling aborted
//   cs_n_o, sclk_o    - SPI chip select (active low) and clock
//   mosi_o, miso_i    - SPI data out (MSB first) and data in
module tpm_spi_ctrl #(
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] ADDR_HI  = 8'hD4,
  parameter int         MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_HDR, ST_WAIT, ST_DATA, ST_HOLD, ST_GUARD
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                abort;
  logic                wr_q;
  logic [7:0]          data_q;
  logic [30:0]         tx_sr;
  logic [7:0]          rx_sr;
  logic [31:0]         header;
  logic                div_end;

  // Size field is zero: every transfer moves exactly one byte.
  assign header  = {(wr_i ? 8'h00 : 8'h80), ADDR_HI, addr_i};
  assign div_end = (div_cnt == DIV_LAST);

  // tx_sr holds the bits still to be sent after the one currently on mosi_o.
  // rx_sr[0] is always the most recent MISO sample, which is what the
  // header-end and wait-byte decisions look at.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      abort     <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 8'h00;
      tx_sr     <= '0;
      rx_sr     <= 8'h00;
      data_o    <= 8'h00;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      cs_n_o    <= 1'b1;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            wr_q    <= wr_i;
            data_q  <= data_i;
            tx_sr   <= header[30:0];
            mosi_o  <= header[31];
            cs_n_o  <= 1'b0;
            busy_o  <= 1'b1;
            abort   <= 1'b0;
            div_cnt <= '0;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_cnt <= 5'd31;
            state   <= ST_HDR;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // Shared bit engine: low phase then high phase per bit. The edge that
        // raises SCLK samples MISO; the edge that drops it advances MOSI or
        // picks the next segment once the current one is exhausted.
        ST_HDR, ST_WAIT, ST_DATA: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk_o) begin
              sclk_o <= 1'b1;
              rx_sr  <= {rx_sr[6:0], miso_i};
            end else begin
              sclk_o <= 1'b0;
              if (bit_cnt != 5'd0) begin
                bit_cnt <= bit_cnt - 5'd1;
                mosi_o  <= tx_sr[30];
                tx_sr   <= {tx_sr[29:0], 1'b0};
              end else if (state == ST_DATA ||
                           (state == ST_WAIT && !rx_sr[0] && wait_cnt == WAIT_LAST)) begin
                abort  <= (state == ST_WAIT);
                mosi_o <= 1'b0;
                state  <= ST_HOLD;
              end else if (rx_sr[0]) begin
                bit_cnt <= 5'd7;
                mosi_o  <= wr_q & data_q[7];
                tx_sr   <= {(wr_q ? data_q[6:0] : 7'h00), 24'h000000};
                state   <= ST_DATA;
              end else begin
                wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
                bit_cnt  <= 5'd7;
                mosi_o   <= 1'b0;
                tx_sr    <= '0;
                state    <= ST_WAIT;
              end
            end
          end
        end

        ST_HOLD: begin
          if (div_end) begin
            div_cnt   <= '0;
            cs_n_o    <= 1'b1;
            done_o    <= 1'b1;
            timeout_o <= abort;
            if (!wr_q && !abort) begin
              data_o <= rx_sr;
            end
            state <= ST_GUARD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // The done cycle is the first guard cycle; busy_o stays up through it
        // so a start coincident with done is dropped.
        ST_GUARD: begin
          done_o    <= 1'b0;
          timeout_o <= 1'b0;
          if (div_end) begin
            div_cnt <= '0;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_spi_ctrl.sv
// tb_tpm_spi_ctrl
// Directed bench for tpm_spi_ctrl. Three instances (CLK_DIV 2/1/5) share the
// stimulus; sel picks which one is started and observed. A small TPM
// peripheral model drives MISO from a per-transaction response table and
// records the MOSI byte stream, SCLK phase lengths and done/timeout pulses.
module tb_tpm_spi_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [1:0]  sel;
  logic        miso;
  logic [2:0]  start_v;
  logic [2:0]  cs_v, sclk_v, mosi_v, busy_v, done_v, to_v;
  logic [7:0]  dout_v [0:2];

  logic        cs_n, sclk, mosi, busy, done, timeout;
  logic [7:0]  dout;

  int total = 0;
  int bad   = 0;

  // Peripheral model / monitor state
  logic [7:0] resp   [0:15];
  logic [7:0] mbytes [0:15];
  logic [7:0] exp_b  [0:6];
  logic [6:0] miso_idx = '0;
  logic [3:0] widx;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       seen_fall = 1'b0;
  int rise_cnt = 0;
  int run = 0;
  int hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
  int done_cnt = 0, to_cnt = 0, rise_cs_high = 0;

  // Results of the last applyStimulus call
  int r_done, r_busy, r_to, r_cs, r_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_v = start ? (3'b001 << sel) : 3'b000;
  assign cs_n    = cs_v[sel];
  assign sclk    = sclk_v[sel];
  assign mosi    = mosi_v[sel];
  assign busy    = busy_v[sel];
  assign done    = done_v[sel];
  assign timeout = to_v[sel];
  assign dout    = dout_v[sel];
  assign widx    = 4'(rise_cnt >> 3);
  assign miso    = resp[miso_idx[6:3]][3'd7 - miso_idx[2:0]];

  tpm_spi_ctrl #(.CLK_DIV(2), .ADDR_HI(8'hD4), .MAX_WAIT(4)) dut_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[0]), .wr_i(wr), .addr_i(addr),
    .data_i(din), .data_o(dout_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
    .timeout_o(to_v[0]), .cs_n_o(cs_v[0]), .sclk_o(sclk_v[0]), .mosi_o(mosi_v[0]),
    .miso_i(miso));

  tpm_spi_ctrl #(.CLK_DIV(1), .ADDR_HI(8'hD4), .MAX_WAIT(16)) dut_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[1]), .wr_i(wr), .addr_i(addr),
    .data_i(din), .data_o(dout_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
    .timeout_o(to_v[1]), .cs_n_o(cs_v[1]), .sclk_o(sclk_v[1]), .mosi_o(mosi_v[1]),
    .miso_i(miso));

  tpm_spi_ctrl #(.CLK_DIV(5), .ADDR_HI(8'hD4), .MAX_WAIT(16)) dut_d5 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_v[2]), .wr_i(wr), .addr_i(addr),
    .data_i(din), .data_o(dout_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
    .timeout_o(to_v[2]), .cs_n_o(cs_v[2]), .sclk_o(sclk_v[2]), .mosi_o(mosi_v[2]),
    .miso_i(miso));

  // Peripheral model: samples the selected instance once per clk cycle,
  // captures MOSI on each SCLK rise, moves MISO to the next bit after each
  // SCLK fall, and measures high/low phase lengths between edges.
  always @(negedge clk) begin
    prev_cs   <= cs_n;
    prev_sclk <= sclk;
    if (!cs_n && prev_cs) begin
      rise_cnt  <= 0;
      miso_idx  <= '0;
      run       <= 0;
      seen_fall <= 1'b0;
      hi_min    <= 1000;
      hi_max    <= 0;
      lo_min    <= 1000;
      lo_max    <= 0;
      done_cnt  <= 0;
      to_cnt    <= 0;
      for (int i = 0; i < 16; i++) mbytes[i] <= 8'h00;
    end else begin
      if (done)    done_cnt <= done_cnt + 1;
      if (timeout) to_cnt   <= to_cnt + 1;
      if (sclk && !prev_sclk) begin
        rise_cnt     <= rise_cnt + 1;
        mbytes[widx] <= {mbytes[widx][6:0], mosi};
        if (cs_n) rise_cs_high <= rise_cs_high + 1;
        if (seen_fall) begin
          if (run < lo_min) lo_min <= run;
          if (run > lo_max) lo_max <= run;
        end
        run <= 1;
      end else if (!sclk && prev_sclk) begin
        if (run < hi_min) hi_min <= run;
        if (run > hi_max) hi_max <= run;
        run       <= 1;
        seen_fall <= 1'b1;
        miso_idx  <= 7'(rise_cnt);
      end else begin
        run <= run + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic setResp(input logic [7:0] b3, input logic [7:0] b4,
                         input logic [7:0] b5, input logic [7:0] b6);
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    resp[3] = b3;
    resp[4] = b4;
    resp[5] = b5;
    resp[6] = b6;
  endtask

  task automatic setExp(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5,
                        input logic [7:0] e6);
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    exp_b[4] = e4; exp_b[5] = e5; exp_b[6] = e6;
  endtask

  task automatic checkBytes(input string pfx, input int n);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_mosi_byte%0d", pfx, i), mbytes[i], exp_b[i]);
  endtask

  task automatic checkPhases(input string pfx, input int d);
    checkOutput({pfx, "_hi_min"}, hi_min, d);
    checkOutput({pfx, "_hi_max"}, hi_max, d);
    checkOutput({pfx, "_lo_min"}, lo_min, d);
    checkOutput({pfx, "_lo_max"}, lo_max, d);
  endtask

  // Starts one transaction on the selected instance and follows it cycle by
  // cycle (cycle 1 = first cycle after the accepting edge). Optionally pulses
  // start mid-transfer with altered inputs, pulses start on the done cycle,
  // or pulls reset at a given cycle. Bounded by a cycle budget.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] d,
                               input int pulse_cyc, input bit pulse_on_done,
                               input int abort_cyc);
    int cyc;
    bit finished;
    cyc = 0;
    finished = 1'b0;
    r_done = -1; r_busy = -1; r_to = -1; r_cs = -1; r_data = -1;
    @(negedge clk);
    wr = w; addr = a; din = d; start = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == pulse_cyc) begin
        start = 1'b1; wr = ~w; addr = ~a; din = ~d;
      end
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_cs_n", cs_n, 1);
        checkOutput("abort_sclk", sclk, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        finished = 1'b1;
      end else if (r_done < 0) begin
        if (done) begin
          r_done = cyc; r_to = timeout; r_cs = cs_n; r_data = dout;
          if (pulse_on_done) start = 1'b1;
        end
      end else if (!busy) begin
        r_busy = cyc;
        finished = 1'b1;
      end
    end
    start = 1'b0;
    if (abort_cyc == 0) checkOutput("txn_completed", int'(r_busy > 0), 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wr = 1'b0; addr = 16'h0000; din = 8'h00; sel = 2'd0;
    setResp(8'h00, 8'h00, 8'h00, 8'h00);
    setExp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", cs_n, 1);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_data", dout, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write, no wait states, CLK_DIV=2");
    setResp(8'h01, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 16'h0018, 8'h5A, 0, 1'b0, 0);
    setExp(8'h00, 8'hD4, 8'h00, 8'h18, 8'h5A, 8'h00, 8'h00);
    checkBytes("wr", 5);
    checkOutput("wr_rises", rise_cnt, 40);
    checkOutput("wr_done_cycle", r_done, 165);
    checkOutput("wr_busy_fall", r_busy, 167);
    checkOutput("wr_timeout", r_to, 0);
    checkOutput("wr_cs_at_done", r_cs, 1);
    checkOutput("wr_done_pulses", done_cnt, 1);
    checkPhases("wr", 2);

    $display("[TB] read, two wait states");
    setResp(8'h00, 8'h00, 8'h01, 8'hA7);
    applyStimulus(1'b0, 16'h0F00, 8'h00, 0, 1'b0, 0);
    setExp(8'h80, 8'hD4, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);
    checkBytes("rd", 7);
    checkOutput("rd_rises", rise_cnt, 56);
    checkOutput("rd_done_cycle", r_done, 229);
    checkOutput("rd_data_at_done", r_data, 8'hA7);
    checkOutput("rd_timeout", r_to, 0);
    checkOutput("rd_data_held", dout, 8'hA7);

    $display("[TB] wait-state timeout, MAX_WAIT=4");
    setResp(8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 16'h0024, 8'h00, 0, 1'b0, 0);
    setExp(8'h80, 8'hD4, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00);
    checkBytes("to", 7);
    checkOutput("to_rises", rise_cnt, 64);
    checkOutput("to_done_cycle", r_done, 261);
    checkOutput("to_timeout_at_done", r_to, 1);
    checkOutput("to_cs_at_done", r_cs, 1);
    checkOutput("to_data_kept", r_data, 8'hA7);
    checkOutput("to_done_pulses", done_cnt, 1);
    checkOutput("to_timeout_pulses", to_cnt, 1);
    checkOutput("to_busy_fall", r_busy, 263);

    $display("[TB] start while busy");
    setResp(8'h01, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 16'h0018, 8'h5A, 40, 1'b1, 0);
    setExp(8'h00, 8'hD4, 8'h00, 8'h18, 8'h5A, 8'h00, 8'h00);
    checkBytes("sb", 5);
    checkOutput("sb_done_cycle", r_done, 165);
    repeat (8) @(negedge clk);
    checkOutput("sb_noqueue_cs", cs_n, 1);
    checkOutput("sb_noqueue_busy", busy, 0);
    checkOutput("sb_rises", rise_cnt, 40);
    checkOutput("sb_done_pulses", done_cnt, 1);

    $display("[TB] reset mid-header");
    applyStimulus(1'b1, 16'h0018, 8'h5A, 0, 1'b0, 70);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rs_no_done", done_cnt, 0);
    checkOutput("rs_cs_idle", cs_n, 1);
    checkOutput("rs_data_cleared", dout, 8'h00);
    applyStimulus(1'b1, 16'h0018, 8'h5A, 0, 1'b0, 0);
    checkBytes("rs", 5);
    checkOutput("rs_done_cycle", r_done, 165);
    checkOutput("rs_rises", rise_cnt, 40);

    $display("[TB] write, CLK_DIV=1");
    sel = 2'd1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 16'h0018, 8'h5A, 0, 1'b0, 0);
    checkBytes("d1", 5);
    checkOutput("d1_rises", rise_cnt, 40);
    checkOutput("d1_done_cycle", r_done, 83);
    checkOutput("d1_busy_fall", r_busy, 84);
    checkPhases("d1", 1);

    $display("[TB] write, CLK_DIV=5");
    sel = 2'd2;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 16'h0018, 8'h5A, 0, 1'b0, 0);
    checkBytes("d5", 5);
    checkOutput("d5_rises", rise_cnt, 40);
    checkOutput("d5_done_cycle", r_done, 411);
    checkOutput("d5_busy_fall", r_busy, 416);
    checkPhases("d5", 5);

    checkOutput("sclk_rise_with_cs_high", rise_cs_high, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
